// File: rtl/usr5_pkg.sv
// Shared types and line-level constants for the usr5 serial deframer.
package usr5_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10,
        STOP   = 2'b11
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/usr5_sync_fifo.sv
// Small synchronous FIFO holding deframed words; a push while full is accepted only alongside a pop.
module usr5_sync_fifo
    import usr5_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/usr5_serial_deframer.sv
// Deframes start/data/parity/stop words from the usr5 shift register SO line into a valid/ready FIFO.
// Optional error/drop counters are enabled with `define USR5_DEFRAMER_ERR_CNT_EN.
module usr5_serial_deframer
    import usr5_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_en,
    output logic [WIDTH-1:0] po_data,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overflow
`ifdef USR5_DEFRAMER_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt,
    output logic [7:0]       drop_cnt
`endif
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_bit;
    logic             push_p1;
    logic [WIDTH-1:0] word_p1;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    function automatic logic parity_bad(input logic [WIDTH-1:0] d, input logic p);
        return ((^d) ^ p) != 1'(PARITY_ODD);
    endfunction

    assign busy     = (state != IDLE);
    assign po_valid = !fifo_empty;
    assign pop      = po_valid && po_ready;

    // Stage p0: bit sampling and frame evaluation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            push_p1    <= 1'b0;
            word_p1    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            push_p1    <= 1'b0;
            if (si_en) begin
                case (state)
                    IDLE: begin
                        if (si == START_BIT) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {si, shreg[WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= si;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        // A bad stop bit outranks a parity error so a frame reports at most once.
                        if (si != STOP_BIT) begin
                            frame_err <= 1'b1;
                        end else if (parity_bad(shreg, par_bit)) begin
                            parity_err <= 1'b1;
                        end else begin
                            push_p1 <= 1'b1;
                            word_p1 <= shreg;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stage p1: FIFO write of the accepted word
    usr5_sync_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_p1),
        .din   (word_p1),
        .pop   (pop),
        .dout  (po_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (push_p1 && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef USR5_DEFRAMER_ERR_CNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt  <= 8'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (parity_err || frame_err) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (push_p1 && fifo_full && !pop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_usr5_serial_deframer.sv
// Directed bench for usr5_serial_deframer (default build, even parity, WIDTH=5, FIFO_DEPTH=4).
module tb_usr5_serial_deframer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       si = 1'b0;
    logic       si_en = 1'b0;
    logic       po_ready = 1'b0;
    logic [4:0] po_data;
    logic       po_valid;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    usr5_serial_deframer #(
        .WIDTH      (5),
        .FIFO_DEPTH (4),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .si         (si),
        .si_en      (si_en),
        .po_data    (po_data),
        .po_valid   (po_valid),
        .po_ready   (po_ready),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            si_en = 1'b0;
            si    = 1'b0;
            tick();
        end
        si    = b;
        si_en = 1'b1;
        tick();
        si_en = 1'b0;
        si    = 1'b0;
    endtask

    task automatic send_frame(input logic [4:0] w, input logic p, input logic s, input bit gap);
        send_bit(1'b1, gap);
        for (int i = 0; i < 5; i++) send_bit(w[i], gap);
        send_bit(p, gap);
        send_bit(s, gap);
    endtask

    task automatic test_reset();
        rst = 1'b0; si = 1'b0; si_en = 1'b0; po_ready = 1'b0;
        #2;
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL reset_po_valid: got %b want 0", po_valid); end
        n_checks++; if (po_data !== 5'd0) begin n_fail++; $display("FAIL reset_po_data: got %b want 00000", po_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got pe=%b fe=%b want 0 0", parity_err, frame_err); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        po_ready = 1'b1;
        send_frame(5'b10101, 1'b1, 1'b0, 1'b0);
        n_checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL good_err: got pe=%b fe=%b want 0 0", parity_err, frame_err); end
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL good_latency: po_valid got %b want 0 at stop edge", po_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b want 0", busy); end
        tick();
        n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid: got %b want 1", po_valid); end
        n_checks++; if (po_data !== 5'b10101) begin n_fail++; $display("FAIL good_data: got %b want 10101", po_data); end
        tick();
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL good_pop: po_valid got %b want 0", po_valid); end
    endtask

    task automatic test_bad_parity();
        send_frame(5'b10101, 1'b0, 1'b0, 1'b0);
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_pulse: got %b want 1", parity_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL parity_fe: got %b want 0", frame_err); end
        tick();
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_width: got %b want 0", parity_err); end
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL parity_drop: po_valid got %b want 0", po_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL parity_busy: got %b want 0", busy); end
    endtask

    task automatic test_bad_stop();
        send_frame(5'b10101, 1'b0, 1'b1, 1'b0);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL stop_pulse: got %b want 1", frame_err); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL stop_pe: got %b want 0", parity_err); end
        tick();
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL stop_width: got %b want 0", frame_err); end
        n_checks++; if (busy !== 1'b0 || po_valid !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got busy=%b po_valid=%b want 0 0", busy, po_valid); end
    endtask

    task automatic test_overflow();
        logic [4:0] w;
        po_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            w = 5'(i);
            send_frame(w, ^w, 1'b0, 1'b0);
        end
        tick();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        po_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (po_valid !== 1'b1 || po_data !== 5'(i)) begin n_fail++; $display("FAIL ovf_order: got valid=%b data=%0d want 1 %0d", po_valid, po_data, i); end
            tick();
        end
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: po_valid got %b want 0", po_valid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        po_ready = 1'b0;
    endtask

    task automatic test_gapped_reset();
        logic [4:0] w;
        rst = 1'b0; tick(); rst = 1'b1; tick();
        po_ready = 1'b0;
        send_frame(5'b00011, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL gap_prefill: po_valid got %b want 1", po_valid); end
        w = 5'b10110;
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(w[i], 1'b1);
        si_en = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_hold: busy got %b want 1", busy); end
        rst = 1'b0;
        #2;
        n_checks++; if (po_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL gap_rst_state: got valid=%b busy=%b want 0 0", po_valid, busy); end
        n_checks++; if (po_data !== 5'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL gap_rst_data: got data=%b ovf=%b want 00000 0", po_data, overflow); end
        tick();
        rst = 1'b1;
        tick();
        po_ready = 1'b1;
        send_frame(5'b01110, 1'b1, 1'b0, 1'b1);
        n_checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL gap_err: got pe=%b fe=%b want 0 0", parity_err, frame_err); end
        tick();
        n_checks++; if (po_valid !== 1'b1 || po_data !== 5'b01110) begin n_fail++; $display("FAIL gap_word: got valid=%b data=%b want 1 01110", po_valid, po_data); end
        tick();
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL gap_pop: po_valid got %b want 0", po_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [4:0] w;
        po_ready = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            w = 5'(i);
            send_frame(w, ^w, 1'b0, 1'b0);
        end
        tick();
        w = 5'd10;
        send_frame(w, ^w, 1'b0, 1'b0);
        po_ready = 1'b1;
        tick();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf: got %b want 0", overflow); end
        for (int i = 7; i <= 10; i++) begin
            n_checks++; if (po_valid !== 1'b1 || po_data !== 5'(i)) begin n_fail++; $display("FAIL full_order: got valid=%b data=%0d want 1 %0d", po_valid, po_data, i); end
            tick();
        end
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL full_count: po_valid got %b want 0", po_valid); end
        po_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_bad_stop();
        test_overflow();
        test_gapped_reset();
        test_full_push_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
